// File: rtl/assignment_update_unit_pkg.sv
// Shared types and default sizing for the assignment update unit.
package assignment_update_unit_pkg;

    // Move handshake state
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam int DEF_INT_INDEX_BITS  = 2;
    localparam int DEF_BOOL_INDEX_BITS = 2;
    localparam int DEF_INT_WIDTH       = 4;
    localparam int DEF_BOOL_WIDTH      = 1;
    localparam int DEF_COUNT_WIDTH     = 16;

endpackage

// File: rtl/assignment_overlay.sv
// Replaces one field of a packed vector with a pending value when enabled.
module assignment_overlay #(
    parameter int INDEX_BITS = 2,
    parameter int WIDTH      = 4
) (
    input  logic [(2**INDEX_BITS)*WIDTH-1:0] current,
    input  logic                             enable,
    input  logic [INDEX_BITS-1:0]            index,
    input  logic [WIDTH-1:0]                 value,
    output logic [(2**INDEX_BITS)*WIDTH-1:0] proposed
);

    // Pass committed state through, overriding only the indexed field
    always_comb begin
        proposed = current;
        if (enable) begin
            proposed[int'(index)*WIDTH +: WIDTH] = value;
        end
    end

endmodule

// File: rtl/assignment_update_unit.sv
// Holds a committed integer/boolean assignment, accepts one move proposal
// at a time and commits or discards it on a decision strobe.
//
// state      | meaning
// ST_IDLE    | ready for a move proposal, decisions ignored
// ST_PENDING | move latched, waiting for accept/reject decision
module assignment_update_unit
    import assignment_update_unit_pkg::*;
#(
    parameter int INT_INDEX_BITS  = DEF_INT_INDEX_BITS,
    parameter int BOOL_INDEX_BITS = DEF_BOOL_INDEX_BITS,
    parameter int INT_WIDTH       = DEF_INT_WIDTH,
    parameter int BOOL_WIDTH      = DEF_BOOL_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
    localparam int NI = 2**INT_INDEX_BITS,
    localparam int NB = 2**BOOL_INDEX_BITS
) (
    input  logic                       in_clk,
    input  logic                       in_reset_n,
    input  logic                       in_load_valid,
    input  logic [NI*INT_WIDTH-1:0]    in_load_integer_assignment,
    input  logic [NB*BOOL_WIDTH-1:0]   in_load_boolean_assignment,
    input  logic                       in_move_valid,
    output logic                       out_move_ready,
    input  logic                       in_move_is_boolean,
    input  logic [INT_INDEX_BITS-1:0]  in_integer_variable_index,
    input  logic [BOOL_INDEX_BITS-1:0] in_boolean_variable_index,
    input  logic [INT_WIDTH-1:0]       in_new_integer_value,
    input  logic [BOOL_WIDTH-1:0]      in_new_boolean_value,
    input  logic                       in_decision_valid,
    input  logic                       in_decision_accept,
    output logic [NI*INT_WIDTH-1:0]    out_current_integer_assignment,
    output logic [NB*BOOL_WIDTH-1:0]   out_current_boolean_assignment,
    output logic [NI*INT_WIDTH-1:0]    out_proposed_integer_assignment,
    output logic [NB*BOOL_WIDTH-1:0]   out_proposed_boolean_assignment,
    output logic                       out_proposal_pending,
    output logic [COUNT_WIDTH-1:0]     out_accept_count,
    output logic [COUNT_WIDTH-1:0]     out_reject_count
);

    state_t                     state;
    logic [NI*INT_WIDTH-1:0]    cur_int;
    logic [NB*BOOL_WIDTH-1:0]   cur_bool;
    logic                       mv_is_bool;
    logic [INT_INDEX_BITS-1:0]  mv_int_idx;
    logic [BOOL_INDEX_BITS-1:0] mv_bool_idx;
    logic [INT_WIDTH-1:0]       mv_int_val;
    logic [BOOL_WIDTH-1:0]      mv_bool_val;
    logic [COUNT_WIDTH-1:0]     accept_count;
    logic [COUNT_WIDTH-1:0]     reject_count;

    // FSM, committed state, latched move and saturating statistics
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state        <= ST_IDLE;
            cur_int      <= '0;
            cur_bool     <= '0;
            mv_is_bool   <= 1'b0;
            mv_int_idx   <= '0;
            mv_bool_idx  <= '0;
            mv_int_val   <= '0;
            mv_bool_val  <= '0;
            accept_count <= '0;
            reject_count <= '0;
        end else if (in_load_valid) begin
            // load wins over any move or decision in the same cycle
            state        <= ST_IDLE;
            cur_int      <= in_load_integer_assignment;
            cur_bool     <= in_load_boolean_assignment;
            accept_count <= '0;
            reject_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_move_valid) begin
                        mv_is_bool  <= in_move_is_boolean;
                        mv_int_idx  <= in_integer_variable_index;
                        mv_bool_idx <= in_boolean_variable_index;
                        mv_int_val  <= in_new_integer_value;
                        mv_bool_val <= in_new_boolean_value;
                        state       <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (in_decision_valid) begin
                        if (in_decision_accept) begin
                            if (mv_is_bool) begin
                                cur_bool[int'(mv_bool_idx)*BOOL_WIDTH +: BOOL_WIDTH] <= mv_bool_val;
                            end else begin
                                cur_int[int'(mv_int_idx)*INT_WIDTH +: INT_WIDTH] <= mv_int_val;
                            end
                            if (accept_count != '1) begin
                                accept_count <= accept_count + COUNT_WIDTH'(1);
                            end
                        end else if (reject_count != '1) begin
                            reject_count <= reject_count + COUNT_WIDTH'(1);
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assignment_overlay #(
        .INDEX_BITS (INT_INDEX_BITS),
        .WIDTH      (INT_WIDTH)
    ) u_int_overlay (
        .current  (cur_int),
        .enable   ((state == ST_PENDING) && !mv_is_bool),
        .index    (mv_int_idx),
        .value    (mv_int_val),
        .proposed (out_proposed_integer_assignment)
    );

    assignment_overlay #(
        .INDEX_BITS (BOOL_INDEX_BITS),
        .WIDTH      (BOOL_WIDTH)
    ) u_bool_overlay (
        .current  (cur_bool),
        .enable   ((state == ST_PENDING) && mv_is_bool),
        .index    (mv_bool_idx),
        .value    (mv_bool_val),
        .proposed (out_proposed_boolean_assignment)
    );

    assign out_move_ready                 = (state == ST_IDLE);
    assign out_proposal_pending           = (state == ST_PENDING);
    assign out_current_integer_assignment = cur_int;
    assign out_current_boolean_assignment = cur_bool;
    assign out_accept_count               = accept_count;
    assign out_reject_count               = reject_count;

endmodule

// File: tb/tb_assignment_update_unit.sv
// Directed bench for the assignment update unit; a second instance with
// 2-bit counters exercises saturation.
module tb_assignment_update_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_int = '0;
    logic [3:0]  load_bool = '0;
    logic        move_valid = 1'b0;
    logic        move_is_bool = 1'b0;
    logic [1:0]  int_idx = '0;
    logic [1:0]  bool_idx = '0;
    logic [3:0]  new_int = '0;
    logic [0:0]  new_bool = '0;
    logic        dec_valid = 1'b0;
    logic        dec_accept = 1'b0;

    logic        ready, pending;
    logic [15:0] cur_int, prop_int;
    logic [3:0]  cur_bool, prop_bool;
    logic [15:0] acc_cnt, rej_cnt;

    logic        ready2, pending2;
    logic [15:0] cur_int2, prop_int2;
    logic [3:0]  cur_bool2, prop_bool2;
    logic [1:0]  acc_cnt2, rej_cnt2;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    assignment_update_unit dut (
        .in_clk                          (clk),
        .in_reset_n                      (rst_n),
        .in_load_valid                   (load_valid),
        .in_load_integer_assignment      (load_int),
        .in_load_boolean_assignment      (load_bool),
        .in_move_valid                   (move_valid),
        .out_move_ready                  (ready),
        .in_move_is_boolean              (move_is_bool),
        .in_integer_variable_index       (int_idx),
        .in_boolean_variable_index       (bool_idx),
        .in_new_integer_value            (new_int),
        .in_new_boolean_value            (new_bool),
        .in_decision_valid               (dec_valid),
        .in_decision_accept              (dec_accept),
        .out_current_integer_assignment  (cur_int),
        .out_current_boolean_assignment  (cur_bool),
        .out_proposed_integer_assignment (prop_int),
        .out_proposed_boolean_assignment (prop_bool),
        .out_proposal_pending            (pending),
        .out_accept_count                (acc_cnt),
        .out_reject_count                (rej_cnt)
    );

    assignment_update_unit #(.COUNT_WIDTH(2)) dut_sat (
        .in_clk                          (clk),
        .in_reset_n                      (rst_n),
        .in_load_valid                   (load_valid),
        .in_load_integer_assignment      (load_int),
        .in_load_boolean_assignment      (load_bool),
        .in_move_valid                   (move_valid),
        .out_move_ready                  (ready2),
        .in_move_is_boolean              (move_is_bool),
        .in_integer_variable_index       (int_idx),
        .in_boolean_variable_index       (bool_idx),
        .in_new_integer_value            (new_int),
        .in_new_boolean_value            (new_bool),
        .in_decision_valid               (dec_valid),
        .in_decision_accept              (dec_accept),
        .out_current_integer_assignment  (cur_int2),
        .out_current_boolean_assignment  (cur_bool2),
        .out_proposed_integer_assignment (prop_int2),
        .out_proposed_boolean_assignment (prop_bool2),
        .out_proposal_pending            (pending2),
        .out_accept_count                (acc_cnt2),
        .out_reject_count                (rej_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic is_b, input logic [1:0] idx, input logic [3:0] val);
        move_valid   = 1'b1;
        move_is_bool = is_b;
        int_idx      = idx;
        bool_idx     = idx;
        new_int      = val;
        new_bool     = val[0];
        step();
        move_valid   = 1'b0;
    endtask

    task automatic do_decide(input logic acc);
        dec_valid  = 1'b1;
        dec_accept = acc;
        step();
        dec_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", ready); else pass_cnt++;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending got %0b want 0", pending); else pass_cnt++;
        total++; if ({cur_int, cur_bool, prop_int, prop_bool} !== 40'h0)
            $display("FAIL reset_vectors got %h want 0", {cur_int, cur_bool, prop_int, prop_bool}); else pass_cnt++;
        total++; if ({acc_cnt, rej_cnt} !== 32'h0) $display("FAIL reset_counts got %h want 0", {acc_cnt, rej_cnt}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        load_valid = 1'b1;
        load_int   = 16'h4321;
        load_bool  = 4'hA;
        step();
        load_valid = 1'b0;
        total++; if (cur_int !== 16'h4321) $display("FAIL load_int got %h want 4321", cur_int); else pass_cnt++;
        total++; if (cur_bool !== 4'hA) $display("FAIL load_bool got %h want a", cur_bool); else pass_cnt++;
        total++; if ({acc_cnt, rej_cnt} !== 32'h0) $display("FAIL load_counts got %h want 0", {acc_cnt, rej_cnt}); else pass_cnt++;
        total++; if (ready !== 1'b1) $display("FAIL load_ready got %0b want 1", ready); else pass_cnt++;
    endtask

    task automatic test_int_accept();
        do_move(1'b0, 2'd2, 4'hF);
        total++; if (pending !== 1'b1 || ready !== 1'b0)
            $display("FAIL int_pending got pend=%0b rdy=%0b want 1/0", pending, ready); else pass_cnt++;
        total++; if (prop_int !== 16'h4F21) $display("FAIL int_proposed got %h want 4f21", prop_int); else pass_cnt++;
        total++; if (cur_int !== 16'h4321) $display("FAIL int_current_hold got %h want 4321", cur_int); else pass_cnt++;
        total++; if (prop_bool !== 4'hA) $display("FAIL int_prop_bool got %h want a", prop_bool); else pass_cnt++;
        do_decide(1'b1);
        total++; if (cur_int !== 16'h4F21) $display("FAIL int_commit got %h want 4f21", cur_int); else pass_cnt++;
        total++; if (acc_cnt !== 16'd1) $display("FAIL int_acc_count got %0d want 1", acc_cnt); else pass_cnt++;
        total++; if (ready !== 1'b1 || pending !== 1'b0)
            $display("FAIL int_back_idle got rdy=%0b pend=%0b want 1/0", ready, pending); else pass_cnt++;
    endtask

    task automatic test_bool_reject();
        do_move(1'b1, 2'd0, 4'h1);
        total++; if (prop_bool !== 4'hB) $display("FAIL bool_proposed got %h want b", prop_bool); else pass_cnt++;
        total++; if (prop_int !== 16'h4F21) $display("FAIL bool_prop_int got %h want 4f21", prop_int); else pass_cnt++;
        do_decide(1'b0);
        total++; if (cur_bool !== 4'hA) $display("FAIL bool_reject_cur got %h want a", cur_bool); else pass_cnt++;
        total++; if (prop_bool !== 4'hA) $display("FAIL bool_reject_prop got %h want a", prop_bool); else pass_cnt++;
        total++; if (rej_cnt !== 16'd1 || acc_cnt !== 16'd1)
            $display("FAIL bool_reject_counts got acc=%0d rej=%0d want 1/1", acc_cnt, rej_cnt); else pass_cnt++;
    endtask

    task automatic test_ignored();
        do_decide(1'b1);
        total++; if (acc_cnt !== 16'd1 || cur_int !== 16'h4F21)
            $display("FAIL idle_decision got acc=%0d int=%h want 1/4f21", acc_cnt, cur_int); else pass_cnt++;
        do_move(1'b0, 2'd0, 4'h7);
        total++; if (prop_int !== 16'h4F27) $display("FAIL idx0_proposed got %h want 4f27", prop_int); else pass_cnt++;
        do_move(1'b0, 2'd1, 4'h0);
        total++; if (prop_int !== 16'h4F27) $display("FAIL pending_move_ignored got %h want 4f27", prop_int); else pass_cnt++;
        do_decide(1'b1);
        total++; if (cur_int !== 16'h4F27 || acc_cnt !== 16'd2)
            $display("FAIL idx0_commit got int=%h acc=%0d want 4f27/2", cur_int, acc_cnt); else pass_cnt++;
    endtask

    task automatic test_load_priority();
        do_move(1'b1, 2'd3, 4'h0);
        total++; if (prop_bool !== 4'h2) $display("FAIL bool3_proposed got %h want 2", prop_bool); else pass_cnt++;
        load_valid = 1'b1;
        load_int   = 16'h1234;
        load_bool  = 4'h5;
        dec_valid  = 1'b1;
        dec_accept = 1'b1;
        move_valid = 1'b1;
        step();
        load_valid = 1'b0;
        dec_valid  = 1'b0;
        move_valid = 1'b0;
        total++; if (cur_int !== 16'h1234 || cur_bool !== 4'h5)
            $display("FAIL prio_load got %h/%h want 1234/5", cur_int, cur_bool); else pass_cnt++;
        total++; if ({acc_cnt, rej_cnt} !== 32'h0) $display("FAIL prio_counts got %h want 0", {acc_cnt, rej_cnt}); else pass_cnt++;
        total++; if (ready !== 1'b1 || pending !== 1'b0 || prop_bool !== 4'h5)
            $display("FAIL prio_idle got rdy=%0b pend=%0b pb=%h want 1/0/5", ready, pending, prop_bool); else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            do_move(1'b0, 2'd1, 4'(i + 8));
            do_decide(1'b1);
        end
        total++; if (acc_cnt2 !== 2'b11) $display("FAIL sat_acc got %0d want 3", acc_cnt2); else pass_cnt++;
        total++; if (acc_cnt !== 16'd5) $display("FAIL wide_acc got %0d want 5", acc_cnt); else pass_cnt++;
        total++; if (cur_int !== 16'h12C4) $display("FAIL sat_commit got %h want 12c4", cur_int); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            do_move(1'b1, 2'd2, 4'h1);
            do_decide(1'b0);
        end
        total++; if (rej_cnt2 !== 2'b11 || rej_cnt !== 16'd4)
            $display("FAIL sat_rej got %0d/%0d want 3/4", rej_cnt2, rej_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_move(1'b0, 2'd3, 4'h9);
        total++; if (pending !== 1'b1) $display("FAIL pre_reset_pending got %0b want 1", pending); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pending !== 1'b0 || ready !== 1'b1)
            $display("FAIL async_state got pend=%0b rdy=%0b want 0/1", pending, ready); else pass_cnt++;
        total++; if ({cur_int, cur_bool, prop_int, prop_bool} !== 40'h0)
            $display("FAIL async_vectors got %h want 0", {cur_int, cur_bool, prop_int, prop_bool}); else pass_cnt++;
        total++; if ({acc_cnt, rej_cnt} !== 32'h0) $display("FAIL async_counts got %h want 0", {acc_cnt, rej_cnt}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (ready !== 1'b1 || acc_cnt !== 16'd0)
            $display("FAIL post_reset got rdy=%0b acc=%0d want 1/0", ready, acc_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_int_accept();
        test_bool_reject();
        test_ignored();
        test_load_priority();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
